// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // Byte offsets of the registers within the window.
    localparam logic [3:0] OFS_TXDATA  = 4'h0;
    localparam logic [3:0] OFS_STATUS  = 4'h4;
    localparam logic [3:0] OFS_DIVISOR = 4'h8;

    // STATUS field positions.
    localparam int unsigned ST_BUSY      = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_EMPTY     = 2;
    localparam int unsigned ST_COUNT_LSB = 4;
    localparam int unsigned ST_COUNT_W   = 3;
    localparam int unsigned ST_OVERFLOW  = 8;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with combinational head output; a push into a full FIFO
// is accepted only when a pop happens on the same edge.
module fifo_sync #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter sitting beside dmem on the core's data port:
// TXDATA/STATUS/DIVISOR window, byte FIFO, and a START/DATA/STOP shifter.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
    parameter int unsigned DEPTH     = 4,
    parameter logic [15:0] DIV_RESET = 16'd867
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] RdData,
    output logic        Sel,
    output logic        DMemWE,
    output logic        tx
);

    import uart_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    tx_state_t   state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] div_q, div_d;
    logic        ovf_q, ovf_d;

    logic [3:0]    ofs;
    logic          reg_we, push, stat_we, div_we, pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;
    logic          unused_bits;

    assign ofs     = {DataAdr[3:2], 2'b00};
    assign Sel     = (DataAdr[31:4] == BASE_ADDR[31:4]) && (DataAdr[3:2] != 2'b11);
    assign DMemWE  = MemWrite & ~Sel;
    assign reg_we  = MemWrite & Sel;
    assign push    = reg_we && (ofs == OFS_TXDATA);
    assign stat_we = reg_we && (ofs == OFS_STATUS);
    assign div_we  = reg_we && (ofs == OFS_DIVISOR);

    assign unused_bits = ^{WriteData[31:16], DataAdr[1:0]};

    fifo_sync #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (WriteData[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // The baud counter reloads from DIVISOR only at state entry and bit
    // boundaries, so a DIVISOR write never shortens the bit in flight.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx      = 1'b1;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    baud_d  = div_q;
                    state_d = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (baud_q == '0) begin
                    baud_d  = div_q;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            DATA: begin
                tx = shift_q[0];
                if (baud_q == '0) begin
                    baud_d  = div_q;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            STOP: begin
                if (baud_q == '0) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        baud_d  = div_q;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (stat_we) begin
            ovf_d = 1'b0;
        end else if (push && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
        div_d = div_we ? WriteData[15:0] : div_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            div_q   <= DIV_RESET;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            div_q   <= div_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        status                                = '0;
        status[ST_BUSY]                       = (state_q != IDLE);
        status[ST_FULL]                       = fifo_full;
        status[ST_EMPTY]                      = fifo_empty;
        status[ST_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(fifo_count);
        status[ST_OVERFLOW]                   = ovf_q;
    end

    always_comb begin
        RdData = '0;
        if (Sel) begin
            case (ofs)
                OFS_STATUS:  RdData = status;
                OFS_DIVISOR: RdData = {16'h0000, div_q};
                default:     RdData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: a line monitor decodes frames against a
// scoreboard of bytes the bench expects to be transmitted.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] RdData;
    logic        Sel, DMemWE, tx;

    mmio_uart_tx #(
        .BASE_ADDR (BASE),
        .DEPTH     (4),
        .DIV_RESET (16'd867)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .RdData    (RdData),
        .Sel       (Sel),
        .DMemWE    (DMemWE),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Line monitor and scoreboard.
    logic [7:0] sb [$];
    int         gaps [$];
    int         cyc = 0;
    bit         mon_en = 1'b0;
    int         mon_L = 4;
    logic       m_samp [64];
    bit         m_active = 1'b0;
    int         m_idx = 0;
    int         m_start = 0;
    int         m_end = 0;
    int         m_gap = 0;
    int         frames_done = 0;
    logic       m_stable;
    logic [9:0] m_fr;
    logic [7:0] m_eb;

    always @(negedge clk) begin
        cyc++;
        if (!mon_en || !reset) begin
            m_active = 1'b0;
            m_idx    = 0;
        end else begin
            if (!m_active && tx === 1'b0) begin
                m_active = 1'b1;
                m_idx    = 0;
                m_start  = cyc;
                m_gap    = m_start - m_end;
            end
            if (m_active) begin
                m_samp[m_idx] = tx;
                m_idx++;
                if (m_idx == 10 * mon_L) begin
                    m_stable = 1'b1;
                    for (int k = 0; k < 10; k++) begin
                        m_fr[k] = m_samp[k * mon_L];
                        for (int j = 0; j < mon_L; j++) begin
                            if (m_samp[k * mon_L + j] !== m_fr[k]) m_stable = 1'b0;
                        end
                    end
                    chk("frame_expected", 32'(sb.size() != 0), 32'd1);
                    m_eb = (sb.size() != 0) ? sb.pop_front() : 8'h00;
                    chk("frame_bits", 32'({m_stable, m_fr[9], m_fr[0], m_fr[8:1]}),
                        32'({1'b1, 1'b1, 1'b0, m_eb}));
                    m_active = 1'b0;
                    m_end    = cyc + 1;
                    gaps.push_back(m_gap);
                    frames_done++;
                end
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        @(negedge clk);
        MemWrite  = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        DataAdr = a;
        #1;
        chk(tag, RdData, exp);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (frames_done < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("frames_done", frames_done, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [7:0] ov_bytes [6];
    logic [7:0] rc_bytes [6];
    logic [9:0] dv_frame;
    logic       ew [34];
    int         c0;

    initial begin
        ov_bytes = '{8'h31, 8'hC4, 8'h0F, 8'hF0, 8'h81, 8'h7E};
        rc_bytes = '{8'h3C, 8'h55, 8'hAA, 8'h01, 8'h80, 8'hE7};

        // Reset values.
        #2 reset = 1'b0;
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        rd_chk("rst_status", BASE + 4, 32'h0000_0004);
        rd_chk("rst_divisor", BASE + 8, 32'd867);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Reset asserted mid-frame.
        wr(BASE + 8, 32'd3);
        wr(BASE + 0, 32'h0000_005A);
        repeat (15) @(negedge clk);
        rd_chk("midframe_busy", BASE + 4, 32'h0000_0005);
        reset = 1'b0;
        #1;
        chk("rst_async_tx", 32'(tx), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold_tx", 32'(tx), 32'd1);
        end
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_release_tx", 32'(tx), 32'd1);
        end
        rd_chk("rst2_status", BASE + 4, 32'h0000_0004);
        rd_chk("rst2_divisor", BASE + 8, 32'd867);

        // Single byte at DIVISOR=3.
        mon_en = 1'b1;
        mon_L = 4;
        frames_done = 0;
        wr(BASE + 8, 32'd3);
        @(negedge clk);
        MemWrite  = 1'b1;
        DataAdr   = BASE;
        WriteData = 32'h0000_00A5;
        sb.push_back(8'hA5);
        @(negedge clk);
        MemWrite = 1'b0;
        rd_chk("push_status", BASE + 4, 32'h0000_0010);
        chk("push_tx_high", 32'(tx), 32'd1);
        @(negedge clk);
        rd_chk("start_status", BASE + 4, 32'h0000_0005);
        chk("start_tx_low", 32'(tx), 32'd0);
        repeat (39) @(negedge clk);
        rd_chk("stop_last_busy", BASE + 4, 32'h0000_0005);
        @(negedge clk);
        rd_chk("frame_done_idle", BASE + 4, 32'h0000_0004);
        chk("single_frames", frames_done, 32'd1);
        chk("single_sb_empty", 32'(sb.size()), 32'd0);

        // Overflow: six pushes on consecutive cycles.
        frames_done = 0;
        gaps.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            MemWrite  = 1'b1;
            DataAdr   = BASE;
            WriteData = 32'(ov_bytes[i]);
            if (i < 5) sb.push_back(ov_bytes[i]);
        end
        @(negedge clk);
        MemWrite = 1'b0;
        rd_chk("ovf_status", BASE + 4, 32'h0000_0143);
        wr(BASE + 4, 32'hFFFF_FFFF);
        rd_chk("ovf_cleared", BASE + 4, 32'h0000_0043);
        wait_frames(5, 400);
        for (int i = 1; i < 5; i++) chk("ovf_b2b_gap", gaps[i], 32'd0);
        @(negedge clk);
        rd_chk("ovf_idle", BASE + 4, 32'h0000_0004);
        chk("ovf_sb_empty", 32'(sb.size()), 32'd0);

        // Push lands on the STOP->START pop edge with the FIFO full.
        frames_done = 0;
        gaps.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            MemWrite  = 1'b1;
            DataAdr   = BASE;
            WriteData = 32'(rc_bytes[i]);
            sb.push_back(rc_bytes[i]);
        end
        @(negedge clk);
        MemWrite = 1'b0;
        rd_chk("race_pre", BASE + 4, 32'h0000_0043);
        repeat (36) @(negedge clk);
        MemWrite  = 1'b1;
        DataAdr   = BASE;
        WriteData = 32'(rc_bytes[5]);
        sb.push_back(rc_bytes[5]);
        @(negedge clk);
        MemWrite = 1'b0;
        rd_chk("race_post", BASE + 4, 32'h0000_0043);
        wait_frames(6, 500);
        for (int i = 1; i < 6; i++) chk("race_b2b_gap", gaps[i], 32'd0);
        @(negedge clk);
        rd_chk("race_idle", BASE + 4, 32'h0000_0004);
        chk("race_sb_empty", 32'(sb.size()), 32'd0);

        // Address decode.
        @(negedge clk);
        MemWrite  = 1'b1;
        DataAdr   = 32'd96;
        WriteData = 32'hDEAD_BEEF;
        #1;
        chk("dmem_we", 32'(DMemWE), 32'd1);
        chk("dmem_sel", 32'(Sel), 32'd0);
        @(negedge clk);
        DataAdr = BASE + 12;
        #1;
        chk("hole_sel", 32'(Sel), 32'd0);
        chk("hole_we", 32'(DMemWE), 32'd1);
        @(negedge clk);
        MemWrite = 1'b0;
        rd_chk("decode_status", BASE + 4, 32'h0000_0004);
        chk("load_sel", 32'(Sel), 32'd1);
        chk("load_we", 32'(DMemWE), 32'd0);
        rd_chk("txdata_read", BASE, 32'h0);
        wr(BASE + 8, 32'hABCD_0002);
        rd_chk("div_upper_ignored", BASE + 8, 32'd2);

        // DIVISOR 3 -> 1 written during data bit 3.
        mon_en = 1'b0;
        wr(BASE + 8, 32'd3);
        dv_frame = {1'b1, 8'h96, 1'b0};
        c0 = 0;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < ((k <= 4) ? 4 : 2); j++) begin
                ew[c0] = dv_frame[k];
                c0++;
            end
        end
        for (int c = 30; c < 34; c++) ew[c] = 1'b1;
        @(negedge clk);
        MemWrite  = 1'b1;
        DataAdr   = BASE;
        WriteData = 32'h0000_0096;
        @(negedge clk);
        MemWrite = 1'b0;
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            #1;
            chk("divchg_tx", 32'(tx), 32'(ew[c]));
            if (c == 17) begin
                MemWrite  = 1'b1;
                DataAdr   = BASE + 8;
                WriteData = 32'd1;
            end else if (c == 18) begin
                MemWrite = 1'b0;
            end
        end
        rd_chk("divchg_idle", BASE + 4, 32'h0000_0004);
        rd_chk("divchg_div", BASE + 8, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the data-memory port of the single-cycle ARM core, in parallel with `dmem`. It decodes the core's `DataAdr`/`MemWrite`/`WriteData` store traffic in a small register window and buffers bytes in a FIFO. It serialises them 8N1, LSB first, on `tx`. `top` uses `Sel` to steer the core's `ReadData` between `dmem` and this block, and to gate the `dmem` write enable.

## Interface
- `BASE_ADDR`, default 32'h0000_0100: word-aligned base of the 3-word register window, outside the `dmem` range.
- `DEPTH`, default 4: FIFO entries. Must be a power of two, ≥2.
- `DIV_RESET`, default 16'd867: reset value of DIVISOR (clocks-per-bit minus 1).
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `MemWrite`, in, 1: core store strobe.
- `DataAdr`, in, 32: core data address.
- `WriteData`, in, 32: core store data.
- `RdData`, out, 32: combinational register read data.
- `Sel`, out, 1: `DataAdr[31:4]` equals `BASE_ADDR[31:4]` and `DataAdr[3:2]` is not 2'b11.
- `DMemWE`, out, 1: `MemWrite & ~Sel`, the write enable for `dmem`.
- `tx`, out, 1: serial line, idles high.

## Operation
- Registers, at word offsets from `BASE_ADDR`:
  - +0 TXDATA: a write pushes `WriteData[7:0]`. Reads return 0.
  - +4 STATUS: read-only fields. Bit0 busy (FSM not IDLE). Bit1 full. Bit2 empty. Bits[6:4] count (0..DEPTH). Bit8 overflow (sticky). A write of any value clears overflow. All other bits read 0.
  - +8 DIVISOR: `[15:0]` read/write. Write data bits [31:16] are ignored.
- Push is accepted when count < DEPTH, or when a pop occurs in the same cycle. Otherwise the byte is dropped and overflow is set.
- TX FSM states:
  - IDLE → START when the FIFO is non-empty. The head byte is popped into the shift register on that same edge.
  - START: `tx`=0 for one bit time, then → DATA.
  - DATA: 8 bits, `shift[0]` driven first, then shift right. A 3-bit bit counter runs 0..7. After bit 7 → STOP.
  - STOP: `tx`=1 for one bit time. Then → START directly if the FIFO is non-empty (pop on that edge), else → IDLE.
- Bit time:
  - The baud counter loads DIVISOR on every state entry and on every bit boundary, then counts down. The bit ends when the counter is 0.
  - The bit time is therefore DIVISOR+1 clocks. DIVISOR=0 gives 1 clock per bit.
  - A DIVISOR write mid-frame takes effect at the next counter reload. The current bit is never truncated.
- Reset (`reset`=0, any time, including mid-frame):
  - State IDLE, `tx`=1, FIFO emptied (pointers and count 0), overflow=0, DIVISOR=`DIV_RESET`, counters 0.
  - Any frame in progress is abandoned with no glitch low.
- `RdData` and `Sel` are purely combinational, so the core's single-cycle load path sees them in the same cycle.

## Timing
- Reset values: `tx`=1. `RdData` and `Sel` follow the address. `DMemWE` = `MemWrite & ~Sel`.
- Push at rising edge N into an empty FIFO with FSM IDLE: empty clears after N. FSM enters START at edge N+1, and `tx` falls after N+1.
- Frame length is 10×(DIVISOR+1) clocks.
- Back-to-back bytes: STOP is followed directly by START with no idle gap.
- Simultaneous push and pop at DEPTH: the push is accepted and count is unchanged.
- Simultaneous push and pop at empty cannot occur, because a pop requires non-empty before the edge.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.

## Structure
- Package `uart_pkg`:
  - `tx_state_t` enum {IDLE, START, DATA, STOP}.
  - Offsets `OFS_TXDATA`=0, `OFS_STATUS`=4, `OFS_DIVISOR`=8.
  - STATUS bit-position constants.
- Sub-module `fifo_sync` (parameters WIDTH, DEPTH):
  - Inputs: push, pop, din.
  - Outputs: dout (head, combinational), full, empty, count.
  - Same asynchronous active-low reset.
- `top` adds the `ReadData` mux `Sel ? RdData : dmem_rd` and drives `dmem` with `DMemWE`.

## Test plan
- Reset values: hold `reset`=0 mid-frame, release → `tx`=1 throughout, STATUS reads 32'h0000_0004, DIVISOR reads 867.
- Single byte: write DIVISOR=3, then TXDATA=8'hA5 → `tx` goes low one cycle after the push edge. Bit sequence 0,1,0,1,0,0,1,0,1,1 with each bit 4 clocks (40-clock frame), then busy=0.
- Overflow: with DIVISOR=3, push 6 bytes on consecutive cycles → 1st is popped immediately, next 4 fill the FIFO, 6th is dropped. STATUS shows full=1, count=4, overflow=1. A write to STATUS clears overflow. Exactly 5 frames go out back-to-back with no idle gap.
- Push/pop race: FIFO full, push on the exact cycle STOP→START pops → byte accepted, count stays 4, overflow stays 0.
- Address decode: store to address 96 → `DMemWE`=1, `Sel`=0, no FIFO change. Store to BASE+12 → `Sel`=0. Load from BASE+4 → `Sel`=1, `RdData`=STATUS in the same cycle.
- Divisor change mid-frame: write DIVISOR=1 during bit 3 at DIVISOR=3 → bit 3 keeps 4 clocks, all later bits take 2 clocks.
